// File: rtl/ipv4_ttl_proc.sv
// ipv4_ttl_proc
//   Reads the Ethernet/IPv4 packet at PKT_BASE. If it is IPv4 with TTL > 1,
//   the engine decrements the TTL and patches the header checksum in place
//   with the RFC 1624 incremental update. ready_o is raised when it finishes.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start_i       level request; one run per rising level (DONE waits for 0)
//   mem_ce_o      access enable
//   mem_we_o      1 = write, 0 = read (only meaningful with mem_ce_o)
//   mem_addr_o    byte address of the access
//   mem_width_o   access size in bytes (1/2/4), 0 when idle
//   mem_data_o    write data, right-aligned, upper bits zero
//   mem_data_i    combinational read data, right-aligned, big-endian
//   ready_o       registered, 1 exactly while in DONE
//   state_o       current FSM state, for observation only
//
// Handshake: there is no valid/ready pair on the memory side. A read returns
// data in the same cycle as mem_ce_o=1/mem_we_o=0 and is captured at that
// cycle's rising edge; a write commits at the rising edge of its cycle.
// start_i is a level: a run begins when IDLE samples start_i=1, and ready_o
// holds until start_i returns to 0.

module ipv4_ttl_proc #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [ADDR_W-1:0] PKT_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              ready_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ETYPE = 3'd1,
    RD_TTL   = 3'd2,
    WR_TTL   = 3'd3,
    RD_CSUM  = 3'd4,
    WR_CSUM  = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] OFF_ETYPE = ADDR_W'(12);
  localparam logic [ADDR_W-1:0] OFF_TTL   = ADDR_W'(22);
  localparam logic [ADDR_W-1:0] OFF_CSUM  = ADDR_W'(24);

  state_t      state, state_nxt;
  logic [15:0] m_q;     // {TTL, protocol} as read
  logic [15:0] hc_q;    // header checksum as read
  logic [15:0] m_new;   // {TTL-1, protocol}
  logic [15:0] hc_new;  // updated checksum
  logic [15:0] rd_half;

  // 16-bit ones-complement add: the carry out of bit 15 wraps into bit 0.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = {1'b0, s[15:0]} + {16'd0, s[16]};
    return s[15:0];
  endfunction

  assign rd_half = mem_data_i[15:0];
  assign m_new   = {m_q[15:8] - 8'd1, m_q[7:0]};
  // HC' = ~(~HC + ~m + m'); a zero result is written unchanged.
  assign hc_new  = ~oc_add(oc_add(~hc_q, ~m_q), m_new);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_q     <= '0;
      hc_q    <= '0;
      ready_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_o <= (state_nxt == DONE);
      if (state == RD_TTL)  m_q  <= rd_half;
      if (state == RD_CSUM) hc_q <= rd_half;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = 4'd0;
    mem_data_o  = '0;
    unique case (state)
      IDLE: begin
        if (start_i) state_nxt = RD_ETYPE;
      end
      RD_ETYPE: begin
        mem_ce_o    = 1'b1;
        mem_addr_o  = PKT_BASE + OFF_ETYPE;
        mem_width_o = 4'd2;
        state_nxt   = (rd_half == 16'h0800) ? RD_TTL : DONE;
      end
      RD_TTL: begin
        mem_ce_o    = 1'b1;
        mem_addr_o  = PKT_BASE + OFF_TTL;
        mem_width_o = 4'd2;
        state_nxt   = (rd_half[15:8] <= 8'd1) ? DONE : WR_TTL;
      end
      WR_TTL: begin
        mem_ce_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = PKT_BASE + OFF_TTL;
        mem_width_o = 4'd1;
        mem_data_o  = DATA_W'(m_new[15:8]);
        state_nxt   = RD_CSUM;
      end
      RD_CSUM: begin
        mem_ce_o    = 1'b1;
        mem_addr_o  = PKT_BASE + OFF_CSUM;
        mem_width_o = 4'd2;
        state_nxt   = WR_CSUM;
      end
      WR_CSUM: begin
        mem_ce_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = PKT_BASE + OFF_CSUM;
        mem_width_o = 4'd2;
        mem_data_o  = DATA_W'(hc_new);
        state_nxt   = DONE;
      end
      DONE: begin
        if (!start_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_ipv4_ttl_proc.sv
module tb_ipv4_ttl_proc;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_width_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        ready_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];
  logic [7:0] exp_mem [0:63];
  int rd_cnt;
  int wr_cnt;
  int bad_wr;

  ipv4_ttl_proc #(.ADDR_W(32), .DATA_W(32), .PKT_BASE(32'h0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .ready_o(ready_o), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational big-endian read, write at the rising edge.
  always_comb begin
    mem_data_i = 32'd0;
    if (mem_ce_o && !mem_we_o && mem_addr_o < 32'd60) begin
      case (mem_width_o)
        4'd1: mem_data_i = {24'd0, mem[mem_addr_o[5:0]]};
        4'd2: mem_data_i = {16'd0, mem[mem_addr_o[5:0]], mem[mem_addr_o[5:0] + 6'd1]};
        4'd4: mem_data_i = {mem[mem_addr_o[5:0]], mem[mem_addr_o[5:0] + 6'd1],
                            mem[mem_addr_o[5:0] + 6'd2], mem[mem_addr_o[5:0] + 6'd3]};
        default: mem_data_i = 32'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_ce_o && !mem_we_o) rd_cnt++;
    if (mem_ce_o && mem_we_o) begin
      wr_cnt++;
      if (mem_width_o == 4'd1 && mem_addr_o == 32'd22)
        mem[22] = mem_data_o[7:0];
      else if (mem_width_o == 4'd2 && mem_addr_o == 32'd24) begin
        mem[24] = mem_data_o[15:8];
        mem[25] = mem_data_o[7:0];
      end else
        bad_wr++;
    end
  end

  // driver tasks
  task automatic load_pkt(input logic [15:0] etype, input logic [7:0] ttl,
                          input logic [7:0] proto, input logic [15:0] hc);
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[12] = etype[15:8]; mem[13] = etype[7:0];
    mem[22] = ttl;         mem[23] = proto;
    mem[24] = hc[15:8];    mem[25] = hc[7:0];
    for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
    rd_cnt = 0; wr_cnt = 0; bad_wr = 0;
  endtask

  // Raise start at a falling edge; return how many rising edges until ready_o
  // (0 when ready_o never came within the budget).
  task automatic run_until_ready(output int edges);
    edges = 0;
    start_i = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) begin
        edges = n;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic count_mem_diffs(output int diffs);
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) diffs++;
  endtask

  task automatic finish_run(input string name, input int exp_rd, input int exp_wr);
    int diffs;
    int rd_before;
    checks++;
    if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
      errors++;
      $display("FAIL %s_access_count: reads=%0d writes=%0d expected reads=%0d writes=%0d",
               name, rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
    count_mem_diffs(diffs);
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL %s_memory: %0d bytes differ (b22=%h b24=%h b25=%h) expected 0 (b22=%h b24=%h b25=%h)",
               name, diffs, mem[22], mem[24], mem[25], exp_mem[22], exp_mem[24], exp_mem[25]);
    end
    checks++;
    if (bad_wr !== 0) begin
      errors++;
      $display("FAIL %s_stray_write: %0d writes outside TTL/checksum, expected 0", name, bad_wr);
    end
    // hold start high in DONE: no re-run, no access
    rd_before = rd_cnt + wr_cnt;
    repeat (4) @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || rd_cnt + wr_cnt !== rd_before || state_o !== 3'd6) begin
      errors++;
      $display("FAIL %s_done_hold: ready=%b accesses=%0d state=%0d expected ready=1 accesses=%0d state=6",
               name, ready_o, rd_cnt + wr_cnt, state_o, rd_before);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL %s_return_idle: ready=%b state=%0d expected ready=0 state=0", name, ready_o, state_o);
    end
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0;
    load_pkt(16'h0800, 8'h40, 8'h11, 16'hB861);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_ce_o, mem_we_o, ready_o} !== 3'b000 || mem_addr_o !== 32'd0 ||
        mem_width_o !== 4'd0 || mem_data_o !== 32'd0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: ce=%b we=%b addr=%h w=%0d d=%h rdy=%b st=%0d expected all 0",
               mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o, ready_o, state_o);
    end
    checks++;
    if (rd_cnt !== 0 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_access: reads=%0d writes=%0d expected 0", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_normal();
    int edges;
    load_pkt(16'h0800, 8'h40, 8'h11, 16'hB861);
    exp_mem[22] = 8'h3F; exp_mem[24] = 8'hB9; exp_mem[25] = 8'h61;
    run_until_ready(edges);
    checks++;
    if (edges !== 6) begin
      errors++;
      $display("FAIL normal_latency: %0d edges expected 6", edges);
    end
    finish_run("normal", 3, 2);
  endtask

  task automatic test_csum_fold();
    int edges;
    load_pkt(16'h0800, 8'h80, 8'h06, 16'hFEFF);
    exp_mem[22] = 8'h7F; exp_mem[24] = 8'h00; exp_mem[25] = 8'h00;
    run_until_ready(edges);
    checks++;
    if (edges !== 6) begin
      errors++;
      $display("FAIL fold_latency: %0d edges expected 6", edges);
    end
    finish_run("fold", 3, 2);
  endtask

  task automatic test_non_ipv4();
    int edges;
    load_pkt(16'h86DD, 8'h40, 8'h11, 16'hB861);
    run_until_ready(edges);
    checks++;
    if (edges !== 2) begin
      errors++;
      $display("FAIL non_ipv4_latency: %0d edges expected 2", edges);
    end
    finish_run("non_ipv4", 1, 0);
  endtask

  task automatic test_ttl_low(input logic [7:0] ttl);
    int edges;
    load_pkt(16'h0800, ttl, 8'h11, 16'h1234);
    run_until_ready(edges);
    checks++;
    if (edges !== 3) begin
      errors++;
      $display("FAIL ttl%0d_latency: %0d edges expected 3", ttl, edges);
    end
    finish_run(ttl == 8'd0 ? "ttl0" : "ttl1", 2, 0);
  endtask

  task automatic test_reset_mid_op();
    int edges;
    bit hit;
    load_pkt(16'h0800, 8'h40, 8'h11, 16'hB861);
    start_i = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (state_o === 3'd3) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrst_reach_wr_ttl: state=%0d expected 3", state_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mem_ce_o, mem_we_o, ready_o} !== 3'b000 || mem_width_o !== 4'd0 ||
        mem_addr_o !== 32'd0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL midrst_outputs: ce=%b we=%b rdy=%b w=%0d st=%0d expected all 0",
               mem_ce_o, mem_we_o, ready_o, mem_width_o, state_o);
    end
    checks++;
    if (mem[22] !== 8'h3F || mem[24] !== 8'hB8 || mem[25] !== 8'h61) begin
      errors++;
      $display("FAIL midrst_memory: b22=%h b24=%h b25=%h expected 3f b8 61", mem[22], mem[24], mem[25]);
    end
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    repeat (2) @(negedge clk);
    // reprocess from TTL 3F with the stale checksum B861:
    // ~B861=479E, ~3F11=C0EE, sum=088D, +3E11=469E, ~ -> B961
    for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
    exp_mem[22] = 8'h3E; exp_mem[24] = 8'hB9; exp_mem[25] = 8'h61;
    rd_cnt = 0; wr_cnt = 0; bad_wr = 0;
    run_until_ready(edges);
    checks++;
    if (edges !== 6) begin
      errors++;
      $display("FAIL midrst_rerun_latency: %0d edges expected 6", edges);
    end
    finish_run("midrst_rerun", 3, 2);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_csum_fold();
    test_non_ipv4();
    test_ttl_low(8'h01);
    test_ttl_low(8'h00);
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
